// File: rtl/gol_vga_renderer_if.sv
// Board-to-display bus between the life engine and the VGA renderer,
// including the renderer's VGA outputs and frame-latch pulse.
interface gol_vga_renderer_if;
    // No valid/ready: board, cursor_en and cursor_row are level signals the
    // renderer may sample at any clock. Only board is captured, once per frame,
    // in the cycle frame is high.
    logic [255:0] board;
    logic         cursor_en;
    logic [3:0]   cursor_row;
    logic         hsync;
    logic         vsync;
    logic [11:0]  rgb;
    logic         frame;

    modport master (
        output board, cursor_en, cursor_row,
        input  hsync, vsync, rgb, frame
    );

    modport slave (
        input  board, cursor_en, cursor_row,
        output hsync, vsync, rgb, frame
    );
endinterface

// File: rtl/gol_vga_renderer.sv
// Renders the 16x16 life board as a cell grid on 640x480@60 VGA, latching the
// board once per frame in vertical blanking so engine updates never tear.
module gol_vga_renderer #(
    parameter int          CLK_DIV    = 4,
    parameter int          CELL_PX    = 28,
    parameter int          X_OFF      = 96,
    parameter int          Y_OFF      = 16,
    parameter logic [11:0] ALIVE_RGB  = 12'h0F0,
    parameter logic [11:0] DEAD_RGB   = 12'h111,
    parameter logic [11:0] GRID_RGB   = 12'h444,
    parameter logic [11:0] CURSOR_RGB = 12'h008
) (
    input logic               ClkPort,
    input logic               reset,
    gol_vga_renderer_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_LAST = 10'd524;
    localparam logic [9:0] H_ACT  = 10'd640;
    localparam logic [9:0] V_ACT  = 10'd480;
    localparam logic [9:0] HS_BEG = 10'd656;
    localparam logic [9:0] HS_END = 10'd751;
    localparam logic [9:0] VS_BEG = 10'd490;
    localparam logic [9:0] VS_END = 10'd491;
    localparam logic [9:0] GX0    = 10'(X_OFF);
    localparam logic [9:0] GX1    = 10'(X_OFF + 16 * CELL_PX);
    localparam logic [9:0] GY0    = 10'(Y_OFF);
    localparam logic [9:0] GY1    = 10'(Y_OFF + 16 * CELL_PX);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             line_end;
    logic             latch;
    logic [SUB_W-1:0] sub_x;
    logic [SUB_W-1:0] sub_y;
    logic [3:0]       cell_x;
    logic [3:0]       cell_y;
    logic [255:0]     shadow;
    logic [11:0]      pix;
    logic [11:0]      rgb_q;
    logic             hsync_q;
    logic             vsync_q;

    assign tick     = (div == DIV_LAST);
    assign line_end = (hcount == H_LAST);
    assign h_next   = line_end ? 10'd0 : hcount + 10'd1;
    assign v_next   = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    assign latch    = tick && (hcount == 10'd0) && (vcount == V_ACT);

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
        end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            hcount <= h_next;
            if (line_end) vcount <= v_next;
        end
    end

    // Sub-pixel/cell counters track the coordinate the main counters are about
    // to take, so they are aligned with hcount/vcount in every cycle.
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            sub_x  <= '0;
            cell_x <= '0;
            sub_y  <= '0;
            cell_y <= '0;
        end else if (tick) begin
            if (h_next == GX0) begin
                sub_x  <= '0;
                cell_x <= '0;
            end else if (sub_x == SUB_LAST) begin
                sub_x  <= '0;
                cell_x <= cell_x + 4'd1;
            end else begin
                sub_x  <= sub_x + SUB_W'(1);
            end
            if (line_end) begin
                if (v_next == GY0) begin
                    sub_y  <= '0;
                    cell_y <= '0;
                end else if (sub_y == SUB_LAST) begin
                    sub_y  <= '0;
                    cell_y <= cell_y + 4'd1;
                end else begin
                    sub_y  <= sub_y + SUB_W'(1);
                end
            end
        end
    end

    // Screen column k shows board bit 15-k, hence the inverted cell_x.
    always_comb begin
        pix = '0;
        if (hcount < H_ACT && vcount < V_ACT &&
            hcount >= GX0 && hcount < GX1 && vcount >= GY0 && vcount < GY1) begin
            if (sub_x == '0 || sub_y == '0) begin
                pix = GRID_RGB;
            end else if (shadow[{cell_y, ~cell_x}]) begin
                pix = ALIVE_RGB;
            end else if (bus.cursor_en && cell_y == bus.cursor_row) begin
                pix = CURSOR_RGB;
            end else begin
                pix = DEAD_RGB;
            end
        end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            shadow  <= '0;
        end else begin
            if (tick) begin
                rgb_q   <= pix;
                hsync_q <= !(hcount >= HS_BEG && hcount <= HS_END);
                vsync_q <= !(vcount >= VS_BEG && vcount <= VS_END);
            end
            if (latch) shadow <= bus.board;
        end
    end

    assign bus.rgb   = rgb_q;
    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.frame = latch;
endmodule

// File: tb/tb_gol_vga_renderer.sv
// Bench for gol_vga_renderer: random boards and cursor settings checked pixel by
// pixel against a coordinate-arithmetic model; vertical jumps skip idle lines.
module tb_gol_vga_renderer;
    localparam int D  = 2;
    localparam int C  = 3;
    localparam int XO = 96;
    localparam int YO = 1;
    localparam logic [11:0] ALIVE = 12'h0F0;
    localparam logic [11:0] DEAD  = 12'h111;
    localparam logic [11:0] GRID  = 12'h444;
    localparam logic [11:0] CURS  = 12'h008;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gol_vga_renderer_if bus ();

    gol_vga_renderer #(
        .CLK_DIV(D), .CELL_PX(C), .X_OFF(XO), .Y_OFF(YO)
    ) dut (
        .ClkPort(clk),
        .reset  (reset),
        .bus    (bus)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    int           bh;
    int           bv;
    logic [255:0] shadow_m;
    logic [255:0] board_a;
    logic [13:0]  exp_q[$];

    task automatic chk(input string tag, input int h, input int v,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at (%0d,%0d): observed %0h expected %0h", tag, h, v, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_board();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Colour of screen pixel (x,y) from the drawing rules, using division.
    function automatic logic [11:0] ref_rgb(input int x, input int y);
        int gx, gy, col, row;
        if (x >= 640 || y >= 480) return 12'h000;
        gx = x - XO;
        gy = y - YO;
        if (gx < 0 || gy < 0 || gx >= 16 * C || gy >= 16 * C) return 12'h000;
        if (gx % C == 0 || gy % C == 0) return GRID;
        col = gx / C;
        row = gy / C;
        if (shadow_m[row * 16 + 15 - col]) return ALIVE;
        if (bus.cursor_en && row == int'(bus.cursor_row)) return CURS;
        return DEAD;
    endfunction

    // One pixel period: check frame every clock, outputs after the update edge.
    task automatic step();
        logic [13:0] e;
        logic        at_latch;
        logic        hs;
        logic        vs;
        at_latch = (bh == 0 && bv == 480);
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            chk("frame", bh, bv, 32'(bus.frame), 32'(at_latch && i == D - 2));
            if (i == D - 2) begin
                hs = !(bh >= 656 && bh <= 751);
                vs = !(bv >= 490 && bv <= 491);
                exp_q.push_back({hs, vs, ref_rgb(bh, bv)});
                if (at_latch) shadow_m = bus.board;
            end
        end
        e = exp_q.pop_front();
        chk("rgb",   bh, bv, 32'(bus.rgb),   32'(e[11:0]));
        chk("hsync", bh, bv, 32'(bus.hsync), 32'(e[13]));
        chk("vsync", bh, bv, 32'(bus.vsync), 32'(e[12]));
        if (bh == 799) begin
            bh = 0;
            bv = (bv == 524) ? 0 : bv + 1;
        end else begin
            bh = bh + 1;
        end
        if ($urandom_range(0, 63) == 0) begin
            bus.cursor_en  = 1'($urandom_range(0, 1));
            bus.cursor_row = 4'($urandom_range(0, 3));
        end
    endtask

    task automatic run_lines(input int n);
        for (int l = 0; l < n; l++) begin
            bus.cursor_en  = 1'($urandom_range(0, 1));
            bus.cursor_row = 4'($urandom_range(0, 3));
            for (int p = 0; p < 800; p++) step();
        end
    endtask

    // Skip to line v at h==0; only used outside the grid rows.
    task automatic jump(input int v);
        force dut.vcount = 10'(v);
        #1;
        release dut.vcount;
        bv = v;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rgb"},   bh, bv, 32'(bus.rgb),   32'h0);
        chk({tag, "_hsync"}, bh, bv, 32'(bus.hsync), 32'h1);
        chk({tag, "_vsync"}, bh, bv, 32'(bus.vsync), 32'h1);
        chk({tag, "_frame"}, bh, bv, 32'(bus.frame), 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.board      = rand_board();
        bus.cursor_en  = 1'b0;
        bus.cursor_row = 4'd0;
        bh             = 0;
        bv             = 0;
        shadow_m       = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // Frame 0: empty shadow, then latch board A and cross vsync.
        run_lines(5);
        jump(479);
        board_a   = rand_board();
        board_a[15] = 1'b1;
        board_a[16] = 1'b1;
        bus.board = board_a;
        run_lines(2);
        bus.board = rand_board();
        jump(488);
        run_lines(5);
        jump(524);
        run_lines(1);

        // Frame 1: board A visible; a mid-frame board change must not show.
        run_lines(5);
        bus.board = ~board_a;
        run_lines(5);
        jump(479);
        run_lines(2);
        jump(524);
        run_lines(1);

        // Frame 2: board ~A visible, then reset mid-line.
        run_lines(6);
        for (int p = 0; p < int'($urandom_range(1, 799)); p++) step();
        #2 reset = 1'b1;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        chk_reset_outputs("midrst_hold");
        reset    = 1'b0;
        bh       = 0;
        bv       = 0;
        shadow_m = '0;
        exp_q.delete();
        run_lines(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached at (%0d,%0d)", bh, bv);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gol_vga_renderer.md
Name: gol_vga_renderer

Overview:
- Consumer end of the Game of Life board interface: reads the 256-bit board bus produced by the life engine and renders it as a 16x16 grid on 640x480@60 Hz VGA.
- Latches the board once per frame during vertical blanking, so engine updates never tear mid-frame.
- Optionally highlights the row currently being edited in SET mode.
- Sits between the life engine and the board's VGA connector.

Parameters:
- CLK_DIV, 4, ClkPort cycles per pixel (100 MHz to 25 MHz); legal values are 2 or more.
- CELL_PX, 28, cell edge length in pixels.
- X_OFF, 96, left pixel of the grid.
- Y_OFF, 16, top line of the grid.
- ALIVE_RGB, 12'h0F0, colour of a live cell.
- DEAD_RGB, 12'h111, colour of a dead cell.
- GRID_RGB, 12'h444, colour of grid lines.
- CURSOR_RGB, 12'h008, colour of a dead cell in the cursor row.

Ports:
- ClkPort  in  1  system clock
- reset  in  1  asynchronous, active-high
- board_i  in  256  board bus; bit r*16+b is row r, bit b
- cursor_en_i  in  1  enables row highlight
- cursor_row_i  in  4  row to highlight
- hsync_o  out  1  horizontal sync, active-low
- vsync_o  out  1  vertical sync, active-low
- rgb_o  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_o  out  1  one-ClkPort pulse when board_i is latched

Behaviour:
- Reset is asynchronous, active-high; clock is ClkPort.
- Reset values: divider 0, hcount 0, vcount 0, shadow board 0, hsync_o=1, vsync_o=1, rgb_o=0, frame_o=0.
- Reset asserted mid-frame restarts the timing at (0,0) on the first tick after deassertion.

Pixel tick and counters:
- Divider counts 0..CLK_DIV-1. tick=1 in the ClkPort cycle where the divider equals CLK_DIV-1; the first tick comes CLK_DIV clocks after reset release.
- On each tick, hcount advances 0..799 and wraps to 0.
- When hcount wraps, vcount advances 0..524 and wraps to 0.

Timing:
- Active region: hcount<640 and vcount<480.
- hsync low for hcount 656..751 inclusive.
- vsync low for vcount 490..491 inclusive.

Grid addressing:
- No dividers. Per-axis sub-pixel counters run 0..CELL_PX-1, and cell counters run 0..15.
- Both axes reset at the grid origin: hcount==X_OFF for columns, vcount==Y_OFF for rows.
- Grid spans x X_OFF..X_OFF+16*CELL_PX-1 and y Y_OFF..Y_OFF+16*CELL_PX-1; with defaults, 96..543 and 16..463.
- Screen column k (0 = leftmost) shows bit r*16+(15-k), so Sw15 maps to the left edge.

Colour priority, evaluated per pixel:
1. Not in the active region: 0.
2. Outside the grid: 0.
3. Sub-pixel x==0 or sub-pixel y==0: GRID_RGB.
4. Cell alive: ALIVE_RGB.
5. cursor_en_i and row==cursor_row_i: CURSOR_RGB.
6. Otherwise: DEAD_RGB.

Output latency:
- rgb_o, hsync_o and vsync_o are registered together.
- They reflect the counter values of the previous tick and update only on tick, so the pipeline delay is 1 pixel on all three.

Board latch:
- On the tick where hcount==0 and vcount==480, the shadow board is loaded from board_i.
- frame_o is high for exactly that one ClkPort cycle.
- Rendering uses only the shadow board; changes to board_i at any other time have no visible effect until the next latch.
- cursor_en_i and cursor_row_i are sampled live and are not latched.

Test Plan:
- Reset and timing: hold reset, then release. Required response: rgb_o=0, hsync_o=1, vsync_o=1, frame_o=0 during reset; hsync_o then has a period of 3200 ClkPort cycles with a low width of 384; vsync_o has a period of 1,680,000 ClkPort cycles with a low width of 6400.
- Latch pulse: run a full frame. Required response: exactly one frame_o pulse per frame, at (h=0, v=480); the board_i value at that instant appears in the next frame.
- Tear protection: set board_i=0, let it latch, then set board_i[255:0]='1 while vcount=100. Required response: the rest of that frame shows DEAD_RGB, and the next frame shows ALIVE_RGB for all cell interiors.
- Pixel mapping: latch board_i with only bit 15 set. Required response: pixel (97,17) is 12'h0F0, pixel (125,17) is 12'h111, pixel (96,17) is 12'h444, pixel (95,17) is 0; pixel (x,y) is sampled on rgb_o one tick after the counters reach (x,y).
- Bit-to-screen ordering: latch only bit 16 (row 1, bit 0). Required response: rightmost cell of row 1, e.g. pixel (530,50), is 12'h0F0.
- Cursor row: board 0, cursor_en_i=1, cursor_row_i=3. Required response: pixels y 101..127 inside the grid are 12'h008; with cursor_en_i=0 they are 12'h111.
- Mid-frame reset: assert reset at v=200, then release. Required response: outputs return to reset values immediately; counting resumes from (0,0); the shadow board is 0 until the next latch.
